// File: rtl/layer_out_serializer.sv
// Collects one activation per neuron lane, then streams them out lane 0 first.
// Optional argmax over the streamed frame is built when MAXFIND_EN is defined.
module layer_out_serializer #(
  parameter int NUM_NEURONS = 30,
  parameter int DATA_WIDTH  = 16,
  parameter int IDX_WIDTH   = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_NEURONS-1:0]            in_valid,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic                              busy,
  output logic                              overrun,
  output logic [IDX_WIDTH-1:0]              max_idx,
  output logic                              max_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_STREAM
  } state_e;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NEURONS - 1);

  state_e                  state_q, state_d;
  logic [NUM_NEURONS-1:0]  mask_q, mask_d;
  logic [DATA_WIDTH-1:0]   hold_q [NUM_NEURONS];
  logic [DATA_WIDTH-1:0]   hold_d [NUM_NEURONS];
  logic [IDX_WIDTH-1:0]    rd_idx_q, rd_idx_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    out_last_q, out_last_d;
  logic                    overrun_q, overrun_d;
  logic                    beat;

  assign beat = out_valid_q & out_ready;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d     = state_q;
    mask_d      = mask_q;
    hold_d      = hold_q;
    rd_idx_d    = rd_idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    overrun_d   = overrun_q;

    // Lanes are only captured outside STREAM; late pulses there are dropped.
    for (int k = 0; k < NUM_NEURONS; k++) begin
      if (state_q != S_STREAM && in_valid[k]) begin
        hold_d[k] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
        mask_d[k] = 1'b1;
      end
    end

    case (state_q)
      S_IDLE, S_COLLECT: begin
        if (&mask_d) begin
          // First word comes from the post-capture buffer so lane 0 may land this cycle.
          state_d     = S_STREAM;
          out_valid_d = 1'b1;
          out_data_d  = hold_d[0];
          out_last_d  = (LAST_IDX == '0);
          rd_idx_d    = '0;
        end else if (|mask_d) begin
          state_d = S_COLLECT;
        end
      end
      S_STREAM: begin
        if (|in_valid) overrun_d = 1'b1;
        if (beat) begin
          if (out_last_q) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = '0;
            rd_idx_d    = '0;
            mask_d      = '0;
          end else begin
            rd_idx_d   = rd_idx_q + IDX_WIDTH'(1);
            out_data_d = hold_q[rd_idx_d];
            out_last_d = (rd_idx_d == LAST_IDX);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q     <= S_IDLE;
      mask_q      <= '0;
      rd_idx_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      rd_idx_q    <= rd_idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      overrun_q   <= overrun_d;
    end
  end

  // NOTE: the holding buffer is not reset; the mask alone says which words are live.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != S_IDLE);
  assign overrun   = overrun_q;

`ifdef MAXFIND_EN
  logic [DATA_WIDTH-1:0] run_max_q, run_max_d;
  logic [IDX_WIDTH-1:0]  run_idx_q, run_idx_d;
  logic [IDX_WIDTH-1:0]  max_idx_q, max_idx_d;
  logic                  max_valid_q, max_valid_d;

  // Strict greater-than keeps the lower index on ties; lane 0 restarts the search.
  always_comb begin
    run_max_d   = run_max_q;
    run_idx_d   = run_idx_q;
    max_idx_d   = max_idx_q;
    max_valid_d = 1'b0;
    if (state_q == S_STREAM && beat) begin
      if (rd_idx_q == '0 || $signed(out_data_q) > $signed(run_max_q)) begin
        run_max_d = out_data_q;
        run_idx_d = rd_idx_q;
      end
      if (out_last_q) begin
        max_idx_d   = run_idx_d;
        max_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_max_q   <= '0;
      run_idx_q   <= '0;
      max_idx_q   <= '0;
      max_valid_q <= 1'b0;
    end else begin
      run_max_q   <= run_max_d;
      run_idx_q   <= run_idx_d;
      max_idx_q   <= max_idx_d;
      max_valid_q <= max_valid_d;
    end
  end

  assign max_idx   = max_idx_q;
  assign max_valid = max_valid_q;
`else
  assign max_idx   = '0;
  assign max_valid = 1'b0;
`endif

endmodule

// File: tb/tb_layer_out_serializer.sv
// Directed bench for layer_out_serializer with four 16-bit lanes.
// Argmax expectations follow whether MAXFIND_EN is defined for the build.
module tb_layer_out_serializer;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int IW = 2;
`ifdef MAXFIND_EN
  localparam bit MAXF = 1'b1;
`else
  localparam bit MAXF = 1'b0;
`endif

  typedef logic [DW-1:0] frame_t [N];

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*DW-1:0] in_data = '0;
  logic [N-1:0]    in_valid = '0;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            out_last;
  logic            busy;
  logic            overrun;
  logic [IW-1:0]   max_idx;
  logic            max_valid;

  int errors = 0;
  int checks = 0;

  layer_out_serializer #(
    .NUM_NEURONS(N),
    .DATA_WIDTH (DW),
    .IDX_WIDTH  (IW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .busy     (busy),
    .overrun  (overrun),
    .max_idx  (max_idx),
    .max_valid(max_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input frame_t f);
    for (int k = 0; k < N; k++) in_data[k*DW +: DW] = f[k];
  endtask

  task automatic send_all(input frame_t f);
    set_data(f);
    in_valid = 4'hF;
    tick();
    in_valid = '0;
  endtask

  // Drains one frame, optionally stalling out_ready on one word; checks argmax after.
  task automatic collect(input string tag, input frame_t exp, input int stall_word,
                         input int stall_len, input int exp_max);
    int idx = 0;
    int waited = 0;
    int stalls = 0;
    while (idx < N && waited < 40) begin
      if (out_valid) begin
        out_ready = !(idx == stall_word && stalls < stall_len);
        if (out_ready) begin
          check({tag, " data"}, 32'(out_data), 32'(exp[idx]));
          check({tag, " last"}, 32'(out_last), 32'(idx == N - 1));
          idx++;
        end else begin
          stalls++;
          check({tag, " held data"}, 32'(out_data), 32'(exp[idx]));
          check({tag, " held last"}, 32'(out_last), 32'(idx == N - 1));
        end
      end
      tick();
      waited++;
    end
    out_ready = 1'b1;
    check({tag, " beats"}, 32'(idx), 32'(N));
    check({tag, " valid after last"}, 32'(out_valid), 32'd0);
    check({tag, " busy after last"}, 32'(busy), 32'd0);
    check({tag, " max_valid pulse"}, 32'(max_valid), 32'(MAXF));
    check({tag, " max_idx"}, 32'(max_idx), MAXF ? 32'(exp_max) : 32'd0);
    tick();
    check({tag, " max_valid drop"}, 32'(max_valid), 32'd0);
    check({tag, " max_idx stable"}, 32'(max_idx), MAXF ? 32'(exp_max) : 32'd0);
  endtask

  initial begin
    frame_t f;
    logic [N-1:0] sched [10];

    tick();
    tick();
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_data", 32'(out_data), 32'd0);
    check("rst out_last", 32'(out_last), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst overrun", 32'(overrun), 32'd0);
    check("rst max_valid", 32'(max_valid), 32'd0);
    check("rst max_idx", 32'(max_idx), 32'd0);
    rst = 1'b0;
    tick();

    // All lanes together: stream starts one cycle later.
    f = '{16'd10, 16'd20, 16'd30, 16'd40};
    send_all(f);
    check("t1 latency valid", 32'(out_valid), 32'd1);
    check("t1 busy", 32'(busy), 32'd1);
    collect("t1", f, -1, 0, 3);

    // Staggered arrival: lane 2,0,3,1 at cycles 0,3,5,9.
    f = '{16'd5, 16'd1, 16'd9, 16'd9};
    set_data(f);
    foreach (sched[c]) sched[c] = '0;
    sched[0] = 4'b0100;
    sched[3] = 4'b0001;
    sched[5] = 4'b1000;
    sched[9] = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      in_valid = sched[c];
      tick();
      in_valid = '0;
      if (c == 8) check("t2 not yet valid", 32'(out_valid), 32'd0);
      if (c == 4) check("t2 busy collecting", 32'(busy), 32'd1);
    end
    check("t2 valid at cycle 10", 32'(out_valid), 32'd1);
    collect("t2", f, -1, 0, 2);

    // Backpressure for three cycles on word 1.
    f = '{16'd100, 16'hFF9C, 16'd50, 16'd25};
    send_all(f);
    collect("t3", f, 1, 3, 0);

    // Overrun: pulse lane 0 while streaming, then an unaffected frame.
    f = '{16'd1, 16'd2, 16'd3, 16'd4};
    send_all(f);
    out_ready = 1'b0;
    in_data[0 +: DW] = 16'd999;
    in_valid = 4'b0001;
    tick();
    in_valid = '0;
    check("t4 overrun set", 32'(overrun), 32'd1);
    check("t4 word0 kept", 32'(out_data), 32'd1);
    out_ready = 1'b1;
    collect("t4a", f, -1, 0, 3);
    f = '{16'd44, 16'd11, 16'd22, 16'd33};
    set_data(f);
    in_valid = 4'b1110;
    tick();
    in_valid = '0;
    check("t4 no preload", 32'(out_valid), 32'd0);
    check("t4 collecting", 32'(busy), 32'd1);
    in_valid = 4'b0001;
    tick();
    in_valid = '0;
    collect("t4b", f, -1, 0, 0);
    check("t4 overrun sticky", 32'(overrun), 32'd1);

    // Reset mid-frame discards the partial frame and clears overrun.
    f = '{16'd7, 16'd7, 16'd0, 16'd0};
    set_data(f);
    in_valid = 4'b0011;
    tick();
    in_valid = '0;
    check("t5 busy before rst", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5 busy", 32'(busy), 32'd0);
    check("t5 out_valid", 32'(out_valid), 32'd0);
    check("t5 overrun", 32'(overrun), 32'd0);
    check("t5 out_data", 32'(out_data), 32'd0);
    check("t5 max_idx", 32'(max_idx), 32'd0);
    f = '{16'd3, 16'd8, 16'd2, 16'd8};
    send_all(f);
    collect("t5", f, -1, 0, 1);

    // Signed argmax with a tie: -5, 7, 7, 3.
    f = '{16'hFFFB, 16'd7, 16'd7, 16'd3};
    send_all(f);
    collect("t6", f, -1, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
